// File: rtl/video_port_regs_pkg.sv
// Shared constants for the video adapter I/O front end: port addresses,
// CRTC register indices, DAC phase encoding and the 6->8 bit colour expansion.
package video_port_regs_pkg;

   localparam logic [15:0] PORT_DAC_RD_IDX = 16'h03C7;
   localparam logic [15:0] PORT_DAC_WR_IDX = 16'h03C8;
   localparam logic [15:0] PORT_DAC_DATA   = 16'h03C9;
   localparam logic [15:0] PORT_CRTC_IDX   = 16'h03D4;
   localparam logic [15:0] PORT_CRTC_DATA  = 16'h03D5;
   localparam logic [15:0] PORT_MODE       = 16'h03D8;
   localparam logic [15:0] PORT_STATUS     = 16'h03DA;

   localparam logic [4:0] CRTC_CUR_START  = 5'h0A;
   localparam logic [4:0] CRTC_CUR_END    = 5'h0B;
   localparam logic [4:0] CRTC_CUR_POS_HI = 5'h0E;
   localparam logic [4:0] CRTC_CUR_POS_LO = 5'h0F;

   typedef enum logic [1:0] {
      PH_R = 2'd0,
      PH_G = 2'd1,
      PH_B = 2'd2
   } dac_phase_t;

   // Replicating the top bits makes 6'h3F map to full-scale 8'hFF.
   function automatic logic [7:0] expand6(input logic [5:0] c6);
      return {c6, c6[5:4]};
   endfunction

endpackage

// File: rtl/video_port_regs_if.sv
// CPU I/O port bus: address, write data, one-cycle strobes and registered read data.
interface video_port_regs_if;
   logic [15:0] port_addr;
   logic [7:0]  port_out;
   logic        port_write;
   logic        port_read;
   logic [7:0]  port_in;

   modport master (
      output port_addr, port_out, port_write, port_read,
      input  port_in
   );

   modport slave (
      input  port_addr, port_out, port_write, port_read,
      output port_in
   );
endinterface

// File: rtl/video_port_regs_dac.sv
// DAC palette port sequencer: write/read indices, R/G/B phase FSMs and the
// assembly of 32-bit palette words from three 6-bit component writes.
module vga_dac_port
   import video_port_regs_pkg::*;
(
   input  logic        clock_25,
   input  logic        reset_n,
   input  logic        wr_idx_load,
   input  logic        rd_idx_load,
   input  logic        data_write,
   input  logic        data_read,
   input  logic [7:0]  wdata,
   output logic [7:0]  wr_idx,
   output logic [7:0]  rd_data,
   output logic        dac_we,
   output logic [7:0]  dac_waddr,
   output logic [31:0] dac_wdata,
   output logic [7:0]  dac_raddr,
   input  logic [31:0] dac_rdata
);

   dac_phase_t  wphase_reg, wphase_next;
   dac_phase_t  rphase_reg, rphase_next;
   logic [7:0]  wr_idx_reg;
   logic [7:0]  rd_idx_reg;
   logic [7:0]  raddr_reg;
   logic [5:0]  red_reg, green_reg;
   logic [5:0]  rd_green_reg, rd_blue_reg;
   logic        dac_we_reg;
   logic [7:0]  dac_waddr_reg;
   logic [31:0] dac_wdata_reg;
   logic        unused_rdata_bits;

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         wphase_reg <= PH_R;
         rphase_reg <= PH_R;
      end else begin
         wphase_reg <= wphase_next;
         rphase_reg <= rphase_next;
      end
   end

   always_comb begin
      wphase_next = wphase_reg;
      rphase_next = rphase_reg;
      if (wr_idx_load) begin
         wphase_next = PH_R;
      end else if (data_write) begin
         case (wphase_reg)
            PH_R:    wphase_next = PH_G;
            PH_G:    wphase_next = PH_B;
            default: wphase_next = PH_R;
         endcase
      end
      if (rd_idx_load) begin
         rphase_next = PH_R;
      end else if (data_read) begin
         case (rphase_reg)
            PH_R:    rphase_next = PH_G;
            PH_G:    rphase_next = PH_B;
            default: rphase_next = PH_R;
         endcase
      end
   end

   // The word is captured on the R read and the next index is requested on the
   // G read, so a back-to-back R read of the following entry finds its data ready.
   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         wr_idx_reg    <= 8'h00;
         rd_idx_reg    <= 8'h00;
         raddr_reg     <= 8'h00;
         red_reg       <= 6'h00;
         green_reg     <= 6'h00;
         rd_green_reg  <= 6'h00;
         rd_blue_reg   <= 6'h00;
         dac_we_reg    <= 1'b0;
         dac_waddr_reg <= 8'h00;
         dac_wdata_reg <= 32'h0000_0000;
      end else begin
         dac_we_reg <= 1'b0;
         if (wr_idx_load) begin
            wr_idx_reg <= wdata;
         end else if (data_write) begin
            case (wphase_reg)
               PH_R: red_reg   <= wdata[5:0];
               PH_G: green_reg <= wdata[5:0];
               default: begin
                  dac_we_reg    <= 1'b1;
                  dac_waddr_reg <= wr_idx_reg;
                  dac_wdata_reg <= {8'h00, expand6(red_reg), expand6(green_reg),
                                    expand6(wdata[5:0])};
                  wr_idx_reg    <= wr_idx_reg + 8'd1;
               end
            endcase
         end

         if (rd_idx_load) begin
            rd_idx_reg <= wdata;
            raddr_reg  <= wdata;
         end else if (data_read) begin
            case (rphase_reg)
               PH_R: begin
                  rd_green_reg <= dac_rdata[15:10];
                  rd_blue_reg  <= dac_rdata[7:2];
               end
               PH_G:    raddr_reg  <= rd_idx_reg + 8'd1;
               default: rd_idx_reg <= rd_idx_reg + 8'd1;
            endcase
         end
      end
   end

   always_comb begin
      rd_data = 8'h00;
      case (rphase_reg)
         PH_R:    rd_data = {2'b00, dac_rdata[23:18]};
         PH_G:    rd_data = {2'b00, rd_green_reg};
         default: rd_data = {2'b00, rd_blue_reg};
      endcase
   end

   assign unused_rdata_bits = ^{dac_rdata[31:24], dac_rdata[17:16],
                                dac_rdata[9:8], dac_rdata[1:0]};

   assign wr_idx    = wr_idx_reg;
   assign dac_we    = dac_we_reg;
   assign dac_waddr = dac_waddr_reg;
   assign dac_wdata = dac_wdata_reg;
   assign dac_raddr = raddr_reg;

endmodule

// File: rtl/video_port_regs.sv
// CPU I/O front end for the video adapter: port decode, CRTC cursor registers,
// mode register, status port and the read-data mux.
module video_port_regs
   import video_port_regs_pkg::*;
#(
   parameter logic [5:0] CUR_LO_RST = 6'd14,
   parameter logic [4:0] CUR_HI_RST = 5'd15
) (
   input  logic               clock_25,
   input  logic               reset_n,
   video_port_regs_if.slave   bus,
   input  logic               vs_in,
   input  logic               de_in,
   output logic [10:0]        cursor,
   output logic [5:0]         cursor_shape_lo,
   output logic [4:0]         cursor_shape_hi,
   output logic [1:0]         videomode,
   output logic               dac_we,
   output logic [7:0]         dac_waddr,
   output logic [31:0]        dac_wdata,
   output logic [7:0]         dac_raddr,
   input  logic [31:0]        dac_rdata
);

   logic       wr_crtc_idx, wr_crtc_data, wr_mode;
   logic       wr_dac_widx, wr_dac_ridx, wr_dac_data;
   logic       rd_accept, rd_dac_data;
   logic [4:0] crtc_idx_reg;
   logic [5:0] r0a_reg;
   logic [4:0] r0b_reg;
   logic [7:0] r0e_reg, r0f_reg;
   logic [1:0] mode_reg;
   logic [7:0] port_in_reg;
   logic [7:0] crtc_rd, rd_mux;
   logic [7:0] dac_wr_idx, dac_rd_data;

   assign wr_crtc_idx  = bus.port_write && (bus.port_addr == PORT_CRTC_IDX);
   assign wr_crtc_data = bus.port_write && (bus.port_addr == PORT_CRTC_DATA);
   assign wr_mode      = bus.port_write && (bus.port_addr == PORT_MODE);
   assign wr_dac_widx  = bus.port_write && (bus.port_addr == PORT_DAC_WR_IDX);
   assign wr_dac_ridx  = bus.port_write && (bus.port_addr == PORT_DAC_RD_IDX);
   assign wr_dac_data  = bus.port_write && (bus.port_addr == PORT_DAC_DATA);

   // A write in the same cycle wins; the read is dropped and port_in holds.
   assign rd_accept    = bus.port_read && !bus.port_write;
   assign rd_dac_data  = rd_accept && (bus.port_addr == PORT_DAC_DATA);

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         crtc_idx_reg <= 5'h00;
         r0a_reg      <= CUR_LO_RST;
         r0b_reg      <= CUR_HI_RST;
         r0e_reg      <= 8'h00;
         r0f_reg      <= 8'h00;
         mode_reg     <= 2'b00;
         port_in_reg  <= 8'h00;
      end else begin
         if (wr_crtc_idx) begin
            crtc_idx_reg <= bus.port_out[4:0];
         end
         if (wr_crtc_data) begin
            case (crtc_idx_reg)
               CRTC_CUR_START:  r0a_reg <= bus.port_out[5:0];
               CRTC_CUR_END:    r0b_reg <= bus.port_out[4:0];
               CRTC_CUR_POS_HI: r0e_reg <= bus.port_out;
               CRTC_CUR_POS_LO: r0f_reg <= bus.port_out;
               default: ;
            endcase
         end
         if (wr_mode) begin
            mode_reg <= bus.port_out[1:0];
         end
         if (rd_accept) begin
            port_in_reg <= rd_mux;
         end
      end
   end

   always_comb begin
      crtc_rd = 8'h00;
      case (crtc_idx_reg)
         CRTC_CUR_START:  crtc_rd = {2'b00, r0a_reg};
         CRTC_CUR_END:    crtc_rd = {3'b000, r0b_reg};
         CRTC_CUR_POS_HI: crtc_rd = r0e_reg;
         CRTC_CUR_POS_LO: crtc_rd = r0f_reg;
         default:         crtc_rd = 8'h00;
      endcase
   end

   always_comb begin
      rd_mux = 8'hFF;
      case (bus.port_addr)
         PORT_CRTC_IDX:   rd_mux = {3'b000, crtc_idx_reg};
         PORT_CRTC_DATA:  rd_mux = crtc_rd;
         PORT_MODE:       rd_mux = {6'b000000, mode_reg};
         PORT_DAC_WR_IDX: rd_mux = dac_wr_idx;
         PORT_DAC_DATA:   rd_mux = dac_rd_data;
         PORT_STATUS:     rd_mux = {4'b0000, vs_in, 2'b00, ~de_in};
         default:         rd_mux = 8'hFF;
      endcase
   end

   vga_dac_port u_dac (
      .clock_25    (clock_25),
      .reset_n     (reset_n),
      .wr_idx_load (wr_dac_widx),
      .rd_idx_load (wr_dac_ridx),
      .data_write  (wr_dac_data),
      .data_read   (rd_dac_data),
      .wdata       (bus.port_out),
      .wr_idx      (dac_wr_idx),
      .rd_data     (dac_rd_data),
      .dac_we      (dac_we),
      .dac_waddr   (dac_waddr),
      .dac_wdata   (dac_wdata),
      .dac_raddr   (dac_raddr),
      .dac_rdata   (dac_rdata)
   );

   assign bus.port_in      = port_in_reg;
   assign cursor           = {r0e_reg[2:0], r0f_reg};
   assign cursor_shape_lo  = r0a_reg;
   assign cursor_shape_hi  = r0b_reg;
   assign videomode        = mode_reg;

endmodule

// File: tb/tb_video_port_regs.sv
// Directed bench for video_port_regs: port reads and palette writes are checked
// against scoreboard queues filled as the stimulus is issued.
module tb_video_port_regs;

   logic        clock_25 = 1'b0;
   logic        reset_n  = 1'b0;
   logic        vs_in, de_in;
   logic [10:0] cursor;
   logic [5:0]  cursor_shape_lo;
   logic [4:0]  cursor_shape_hi;
   logic [1:0]  videomode;
   logic        dac_we;
   logic [7:0]  dac_waddr, dac_raddr;
   logic [31:0] dac_wdata, dac_rdata;

   video_port_regs_if bus();

   always #20 clock_25 = ~clock_25;

   video_port_regs dut (
      .clock_25        (clock_25),
      .reset_n         (reset_n),
      .bus             (bus),
      .vs_in           (vs_in),
      .de_in           (de_in),
      .cursor          (cursor),
      .cursor_shape_lo (cursor_shape_lo),
      .cursor_shape_hi (cursor_shape_hi),
      .videomode       (videomode),
      .dac_we          (dac_we),
      .dac_waddr       (dac_waddr),
      .dac_wdata       (dac_wdata),
      .dac_raddr       (dac_raddr),
      .dac_rdata       (dac_rdata)
   );

   // Palette RAM with registered read; preload port lets the bench seed words.
   logic [31:0] pal [256];
   logic        preload_en = 1'b0;
   logic [7:0]  preload_addr = 8'h00;
   logic [31:0] preload_data = 32'h0;

   always @(posedge clock_25) begin
      if (dac_we) pal[dac_waddr] <= dac_wdata;
      else if (preload_en) pal[preload_addr] <= preload_data;
      dac_rdata <= pal[dac_raddr];
   end

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [7:0] val;
   } rd_exp_t;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_exp_t;

   rd_exp_t rdq[$];
   wr_exp_t wrq[$];
   wr_exp_t mon_e;
   logic [7:0] burst_exp [9];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_read();
      rd_exp_t e;
      if (rdq.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL rdq_underflow observed=empty expected=entry");
      end else begin
         e = rdq.pop_front();
         check(e.tag, {24'h0, bus.port_in}, {24'h0, e.val});
         $display("read  %-14s port_in=%h expected=%h", e.tag, bus.port_in, e.val);
      end
   endtask

   always @(negedge clock_25) begin
      if (dac_we === 1'b1) begin
         if (wrq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL dac_we_unexpected observed=1 expected=0 addr=%h", dac_waddr);
         end else begin
            mon_e = wrq.pop_front();
            check("dac_waddr", {24'h0, dac_waddr}, {24'h0, mon_e.addr});
            check("dac_wdata", dac_wdata, mon_e.data);
            $display("dac   write addr=%h data=%h expected=%h/%h",
                     dac_waddr, dac_wdata, mon_e.addr, mon_e.data);
         end
      end
   end

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      @(negedge clock_25);
      bus.port_addr  = a;
      bus.port_out   = d;
      bus.port_write = 1'b1;
      @(negedge clock_25);
      bus.port_write = 1'b0;
      $display("write port=%h data=%h", a, d);
   endtask

   task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string tag);
      @(negedge clock_25);
      bus.port_addr = a;
      bus.port_read = 1'b1;
      rdq.push_back('{tag, exp});
      @(negedge clock_25);
      bus.port_read = 1'b0;
      pop_read();
   endtask

   task automatic rd_burst(input int n);
      @(negedge clock_25);
      bus.port_addr = 16'h03C9;
      bus.port_read = 1'b1;
      rdq.push_back('{"dac_burst", burst_exp[0]});
      for (int i = 1; i < n; i++) begin
         @(negedge clock_25);
         pop_read();
         rdq.push_back('{"dac_burst", burst_exp[i]});
      end
      @(negedge clock_25);
      bus.port_read = 1'b0;
      pop_read();
   endtask

   task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
      wrq.push_back('{a, d});
   endtask

   initial begin
      bus.port_addr  = 16'h0;
      bus.port_out   = 8'h0;
      bus.port_write = 1'b0;
      bus.port_read  = 1'b0;
      vs_in = 1'b0;
      de_in = 1'b1;

      // Reset state
      repeat (3) @(negedge clock_25);
      check("rst_cursor",   {21'h0, cursor}, 32'h0);
      check("rst_shape_lo", {26'h0, cursor_shape_lo}, 32'd14);
      check("rst_shape_hi", {27'h0, cursor_shape_hi}, 32'd15);
      check("rst_videomode", {30'h0, videomode}, 32'h0);
      check("rst_port_in",  {24'h0, bus.port_in}, 32'h0);
      check("rst_dac_raddr", {24'h0, dac_raddr}, 32'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock_25);

      // CRTC cursor registers
      wr(16'h03D4, 8'h0E);
      wr(16'h03D5, 8'h07);
      wr(16'h03D4, 8'h0F);
      wr(16'h03D5, 8'hCF);
      check("cursor_pos", {21'h0, cursor}, 32'h7CF);
      rd(16'h03D5, 8'hCF, "crtc_r0f");
      wr(16'h03D4, 8'h0A);
      wr(16'h03D5, 8'h05);
      wr(16'h03D4, 8'h0B);
      wr(16'h03D5, 8'h09);
      check("shape_lo", {26'h0, cursor_shape_lo}, 32'h05);
      check("shape_hi", {27'h0, cursor_shape_hi}, 32'h09);
      rd(16'h03D5, 8'h09, "crtc_r0b");
      wr(16'h03D4, 8'h03);
      wr(16'h03D5, 8'hAA);
      rd(16'h03D5, 8'h00, "crtc_unmapped");
      rd(16'h03D4, 8'h03, "crtc_idx");
      rd(16'h0100, 8'hFF, "port_unmapped");
      check("cursor_kept", {21'h0, cursor}, 32'h7CF);

      // Palette write with index wrap
      wr(16'h03C8, 8'hFF);
      rd(16'h03C8, 8'hFF, "dac_widx");
      push_wr(8'hFF, 32'h00FF0082);
      wr(16'h03C9, 8'h3F);
      wr(16'h03C9, 8'h00);
      wr(16'h03C9, 8'h20);
      push_wr(8'h00, 32'h0004080C);
      wr(16'h03C9, 8'h01);
      wr(16'h03C9, 8'h02);
      wr(16'h03C9, 8'h03);
      rd(16'h03C8, 8'h01, "dac_widx_wrap");

      // Reset aborts a partial triple
      wr(16'h03C8, 8'h10);
      wr(16'h03C9, 8'h3F);
      wr(16'h03C9, 8'h3F);
      @(negedge clock_25);
      reset_n = 1'b0;
      @(negedge clock_25);
      check("rst2_cursor", {21'h0, cursor}, 32'h0);
      check("rst2_shape_lo", {26'h0, cursor_shape_lo}, 32'd14);
      reset_n = 1'b1;
      push_wr(8'h00, 32'h00282C30);
      wr(16'h03C9, 8'h0A);
      wr(16'h03C9, 8'h0B);
      wr(16'h03C9, 8'h0C);
      rd(16'h03C8, 8'h01, "dac_widx_post");

      // Palette read-back, including back-to-back reads across entries
      @(negedge clock_25);
      preload_en   = 1'b1;
      preload_addr = 8'h05;
      preload_data = 32'h00FC8000;
      @(negedge clock_25);
      preload_addr = 8'h06;
      preload_data = 32'h00123456;
      @(negedge clock_25);
      preload_addr = 8'h07;
      preload_data = 32'h00FFFFFF;
      @(negedge clock_25);
      preload_en = 1'b0;
      wr(16'h03C7, 8'h05);
      check("raddr_load", {24'h0, dac_raddr}, 32'h05);
      burst_exp[0] = 8'h3F; burst_exp[1] = 8'h20; burst_exp[2] = 8'h00;
      rd_burst(3);
      check("raddr_after3", {24'h0, dac_raddr}, 32'h06);
      burst_exp[0] = 8'h04; burst_exp[1] = 8'h0D; burst_exp[2] = 8'h15;
      burst_exp[3] = 8'h3F; burst_exp[4] = 8'h3F; burst_exp[5] = 8'h3F;
      rd_burst(6);
      check("raddr_after9", {24'h0, dac_raddr}, 32'h08);

      // Write and read in the same cycle, then mode and status reads
      wr(16'h03D4, 8'h0F);
      rd(16'h03D4, 8'h0F, "crtc_idx2");
      @(negedge clock_25);
      bus.port_addr  = 16'h03D8;
      bus.port_out   = 8'h02;
      bus.port_write = 1'b1;
      bus.port_read  = 1'b1;
      rdq.push_back('{"collide_hold", 8'h0F});
      @(negedge clock_25);
      bus.port_write = 1'b0;
      bus.port_read  = 1'b0;
      pop_read();
      check("videomode", {30'h0, videomode}, 32'h2);
      rd(16'h03D8, 8'h02, "mode_read");
      vs_in = 1'b1;
      de_in = 1'b0;
      rd(16'h03DA, 8'h09, "status_vs");
      vs_in = 1'b0;
      de_in = 1'b1;
      rd(16'h03DA, 8'h00, "status_idle");

      repeat (3) @(negedge clock_25);
      check("wrq_drained", wrq.size(), 32'h0);
      check("rdq_drained", rdq.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
